// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit simple processor: address/instruction widths
// and the reset polarity used by fetch, decode, PC logic and the stack.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam int FETCH_DEPTH = 4;
  localparam logic RESET_ACTIVE = 1'b0;

  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: the ROM read port, the redirect request and the decode-side
// valid/ready output of the fetch queue.
interface fetch_queue_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W,
  parameter int DEPTH  = cpu_pkg::FETCH_DEPTH
);
  import cpu_pkg::*;

  localparam int CNT_W = countWidth(DEPTH);

  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;

  // The fetch queue itself is the slave; the ROM/decode/branch environment is the master.
  modport slave (
    input  rom_data, redirect, redirect_pc, out_ready,
    output rom_addr, out_valid, out_inst, out_pc, count
  );

  modport master (
    output rom_data, redirect, redirect_pc, out_ready,
    input  rom_addr, out_valid, out_inst, out_pc, count
  );

endinterface

// File: rtl/fetch_queue_inst_fifo.sv
// Parameterised synchronous FIFO holding fetched {pc, inst} entries; flush empties
// it in one cycle and takes priority over push/pop.
module inst_fifo #(
  parameter int WIDTH = cpu_pkg::ADDR_W + cpu_pkg::INST_W,
  parameter int DEPTH = cpu_pkg::FETCH_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);
  import cpu_pkg::*;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_doPush;
  logic             w_doPop;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_doPop  = i_pop & ~w_empty;
  // A pop frees the slot the push needs, so a full FIFO still accepts a write.
  assign w_doPush = i_push & (~w_full | w_doPop);

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_doPush && w_doPop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns fetch_pc, reads the combinational ROM each cycle
// and buffers {pc, inst} for decode; a redirect reloads fetch_pc and flushes.
module fetch_queue #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W,
  parameter int DEPTH  = cpu_pkg::FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave fq
);
  import cpu_pkg::*;

  localparam int CNT_W   = countWidth(DEPTH);
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  r_fetchPc;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;

  assign w_full = (w_count == CNT_W'(DEPTH));
  assign w_pop  = fq.out_valid & fq.out_ready;
  assign w_push = ~fq.redirect & (~w_full | w_pop);

  inst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (fq.redirect),
    .i_data  ({r_fetchPc, fq.rom_data}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // fetch_pc wraps silently at 2^ADDR_W; a redirect overrides any pending push.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      r_fetchPc <= '0;
    end else if (fq.redirect) begin
      r_fetchPc <= fq.redirect_pc;
    end else if (w_push) begin
      r_fetchPc <= r_fetchPc + ADDR_W'(1);
    end
  end

  assign fq.rom_addr  = r_fetchPc;
  assign fq.count     = w_count;
  assign fq.out_valid = (w_count != '0);
  assign fq.out_pc    = w_head[ENTRY_W-1:INST_W];
  assign fq.out_inst  = w_head[INST_W-1:0];

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage for the 8-bit simple processor. It owns the fetch address and reads the combinational instruction ROM every cycle. Fetched words are buffered, each with its PC, in a small FIFO. The decode stage drains the FIFO through a valid/ready handshake, which decouples decode stalls from fetch. The PC-load path (taken branch or stack return) redirects fetch and flushes the buffer.

## Interface
Parameters:
- ADDR_W, 8, instruction address width (PC width).
- INST_W, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-low. reset==0 at a rising edge initialises all state.
- rom_addr  out  ADDR_W  address to instruction ROM; equals the internal fetch_pc.
- rom_data  in  INST_W  ROM word for rom_addr, valid combinationally in the same cycle.
- redirect  in  1  load a new fetch address and flush the buffer.
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect==1.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  INST_W  head instruction word.
- out_pc  out  ADDR_W  address of the head instruction; feeds the branch adder and the stack push.
- count  out  clog2(DEPTH)+1  number of occupied entries.

## Operation
- State: fetch_pc, FIFO storage of DEPTH × {ADDR_W pc, INST_W inst}, rd_ptr, wr_ptr, count.
- pop = out_valid & out_ready.
- push = !redirect & (count < DEPTH | pop). A push writes {fetch_pc, rom_data} at wr_ptr and sets fetch_pc <= fetch_pc + 1.
- Full with a pop in the same cycle: push and pop both occur, and count is unchanged.
- Full with no pop: no push, and fetch_pc holds.
- Empty: out_valid=0. out_inst and out_pc show the stale slot at rd_ptr, and the consumer must ignore them.
- Redirect:
  - count <= 0 and rd_ptr = wr_ptr <= 0.
  - fetch_pc <= redirect_pc.
  - No push that cycle.
  - A simultaneous pop is absorbed by the flush; the head counts as consumed.
- Priority: reset > redirect > push/pop.
- Arithmetic:
  - fetch_pc increments modulo 2^ADDR_W; 255 wraps to 0 with no flag.
  - Pointers wrap modulo DEPTH.
  - count = pushes − pops and never exceeds DEPTH.
- Reset values: fetch_pc=0, rom_addr=0, count=0, rd_ptr=wr_ptr=0, out_valid=0. Storage is cleared to 0, so out_inst=0 and out_pc=0.
- Reset asserted mid-operation discards all entries and any pending redirect.

## Timing
- All outputs are register-driven, except out_valid, which is decoded from count. There is no combinational path from out_ready to out_valid.
- out_ready → push is a combinational path (full-with-pop case) and is allowed.
- First instruction after reset release: the first edge with reset==1 enqueues PC 0. out_valid=1 with out_pc=0 in the following cycle.
- With out_ready held at 1 and no redirects, the stage sustains one instruction per cycle at steady state.
- Redirect sampled at edge E:
  - Cycle after E: out_valid=0 and rom_addr=redirect_pc.
  - Edge E+1 enqueues the target.
  - The target is visible with out_valid=1 after E+1.
  - Redirect penalty is 2 edges.
- Back-to-back redirects: the later one wins, and the queue stays empty until the first cycle with no redirect.

## Structure
- Shared package cpu_pkg holds ADDR_W=8, INST_W=16, and the RESET_ACTIVE=1'b0 constant. The decoder, PC logic and stack use the same package.
- One sub-module: inst_fifo, a parameterised synchronous FIFO with push, pop, flush, count and head outputs. fetch_queue adds fetch_pc, the push/redirect control, and the ROM interface.

## Test plan
- Reset then free run: ROM[i]=16'hA000+i, out_ready=1. out_valid rises 1 cycle after release, and out_pc/out_inst go 0/A000, 1/A001, 2/A002… one per cycle.
- Backpressure: out_ready=0 for 10 cycles.
  - count saturates at 4 and fetch_pc stops at 4.
  - Release out_ready: entries 0–3 drain in order, then 4, 5… with no gaps or duplicates.
- Redirect with a full queue: redirect=1 and redirect_pc=8'h40 while full and out_ready=1.
  - Next cycle: count=0 and out_valid=0.
  - Two edges after the redirect edge: out_pc=0x40 and out_inst=ROM[0x40].
- Wrap-around: redirect to 8'hFE. The bench sees out_pc FE, FF, 00, 01 in sequence.
- Full with simultaneous pop: full, out_ready=1 for one cycle. count stays 4, the head advances by one, and the tail gains the next fetch_pc.
- Reset mid-run: reset=0 for one edge during a redirect with the queue partially full.
  - Afterwards: count=0, out_valid=0, rom_addr=0.
  - The first out_pc after release is 0.
